schmidl_cox_detector: RTL and testbench

//  Receive-side Schmidl-Cox timing synchroniser: the partner of the TX preamble ROM.
//  - Takes the ADC sample stream (10-bit offset binary, midscale 0x200).
//  - Runs the delayed autocorrelation P(n) and energy R(n) over two identical L-sample halves.
//  - Pulses o_detect at the end of the metric plateau and reports the peak sample index.
//  - Sits between the ADC capture stage and the frame-timing / sync-pulse generator.

---
 rtl/schmidl_cox_detector_pkg.sv | 31 +++
 rtl/schmidl_cox_detector_delay_ram.sv | 41 ++++
 rtl/schmidl_cox_detector.sv | 228 ++++++++++++++++++++++
 tb/tb_schmidl_cox_detector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/schmidl_cox_detector_pkg.sv
// Shared constants and types for the Schmidl-Cox timing detector.
//   DW, L        sample width and half-preamble length
//   P_W, R_W     exact widths of the running correlation and energy sums
//   MID          offset-binary midscale of the ADC samples
//   sc_state_e   detector FSM encoding
package schmidl_cox_detector_pkg;

    localparam int DW    = 10;
    localparam int L     = 64;
    localparam int BUF_D = 2 * L;
    localparam int PTR_W = $clog2(BUF_D);
    localparam int IDX_W = 16;
    localparam int MID   = 1 << (DW - 1);

    // |P| <= L * 2^(2*(DW-1)) needs one sign bit on top; R never goes negative.
    localparam int P_W = 2 * DW + $clog2(L);   // 26
    localparam int R_W = P_W - 1;              // 25

    typedef enum logic [1:0] {
        ST_WARMUP,
        ST_SEARCH,
        ST_TRACK,
        ST_HOLDOFF
    } sc_state_e;

    // Offset binary to two's complement: subtracting midscale in DW bits.
    function automatic logic signed [DW-1:0] remove_offset(input logic [DW-1:0] x);
        return $signed(x - DW'(MID));
    endfunction

endpackage

// File: rtl/schmidl_cox_detector_delay_ram.sv
// sc_delay_ram: 2L x DW circular sample buffer with two registered reads.
//   clk, reset  sample clock, asynchronous active-low reset (read regs only)
//   we          write/advance strobe (one accepted sample)
//   ptr         current write slot
//   wdata       sample s[n] written into slot ptr
//   rd_l        s[n-L]  (slot ptr-L), registered
//   rd_2l       s[n-2L] (old content of slot ptr), registered
module sc_delay_ram
    import schmidl_cox_detector_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [PTR_W-1:0]        ptr,
    input  logic signed [DW-1:0]    wdata,
    output logic signed [DW-1:0]    rd_l,
    output logic signed [DW-1:0]    rd_2l
);

    logic signed [DW-1:0] mem [BUF_D];
    logic [PTR_W-1:0]     ptr_l;

    // Buffer depth is a power of two, so the subtraction wraps for free.
    assign ptr_l = ptr - PTR_W'(L);

    always_ff @(posedge clk) begin
        if (we) mem[ptr] <= wdata;
    end

    // Read-before-write on slot ptr returns the sample from 2L ago.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_l  <= '0;
            rd_2l <= '0;
        end else if (we) begin
            rd_l  <= mem[ptr_l];
            rd_2l <= mem[ptr];
        end
    end

endmodule

// File: rtl/schmidl_cox_detector.sv
// schmidl_cox_detector: Schmidl-Cox preamble timing synchroniser.
//   clk         sample-domain clock
//   reset       asynchronous active-low reset
//   i_valid     i_data valid; all sample processing advances only on it
//   i_data      ADC sample, offset binary
//   o_detect    one-cycle pulse when a preamble plateau has been closed
//   o_peak_idx  sample index of max P inside the plateau, held between detects
//   o_busy      high in warm-up, tracking and hold-off
// Optional (macro SC_DET_DEBUG_EN): o_metric_p / o_metric_r / o_metric_valid
// expose the running sums per accepted sample at the decision stage.
// Pipeline: buffer read + offset removal, products, accumulate, compare+FSM.
module schmidl_cox_detector
    import schmidl_cox_detector_pkg::*;
#(
    parameter int THR        = 192,
    parameter int MIN_ENERGY = 4096,
    parameter int TRACK_MAX  = 32,
    parameter int HOLDOFF    = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DW-1:0]     i_data,
    output logic              o_detect,
    output logic [IDX_W-1:0]  o_peak_idx,
    output logic              o_busy
`ifdef SC_DET_DEBUG_EN
    ,
    output logic signed [P_W-1:0] o_metric_p,
    output logic [R_W-1:0]        o_metric_r,
    output logic                  o_metric_valid
`endif
);

    localparam int CNT_W = 9;

    // vld_pipe[0]: stage-1 regs, [1]: products, [2]: sums hold this sample
    logic [2:0]            vld_pipe;
    logic [PTR_W-1:0]      wr_ptr;
    logic [IDX_W-1:0]      smp_cnt;
    logic [PTR_W:0]        fill_cnt;
    logic signed [DW-1:0]  s0, s1, rd_l, rd_2l, d_l, d_2l;
    logic                  has_l1, has_2l1;
    logic [IDX_W-1:0]      idx1, idx2, idx3;
    logic signed [2*DW-1:0] pa2, pb2, ea2, eb2;
    logic signed [P_W-1:0] p_acc;
    logic [R_W-1:0]        r_acc;

    assign s0 = remove_offset(i_data);

    sc_delay_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (i_valid),
        .ptr   (wr_ptr),
        .wdata (s0),
        .rd_l  (rd_l),
        .rd_2l (rd_2l)
    );

    // Stage 1: pointer/counters and the sample itself. fill_cnt marks which
    // delayed taps hold real post-reset data, so stale buffer contents never
    // enter the sums.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            wr_ptr   <= '0;
            smp_cnt  <= '0;
            fill_cnt <= '0;
            s1       <= '0;
            has_l1   <= 1'b0;
            has_2l1  <= 1'b0;
            idx1     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], i_valid};
            if (i_valid) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                smp_cnt <= smp_cnt + IDX_W'(1);
                if (fill_cnt != (PTR_W+1)'(BUF_D)) fill_cnt <= fill_cnt + (PTR_W+1)'(1);
                s1      <= s0;
                has_l1  <= (fill_cnt >= (PTR_W+1)'(L));
                has_2l1 <= (fill_cnt == (PTR_W+1)'(BUF_D));
                idx1    <= smp_cnt;
            end
        end
    end

    assign d_l  = has_l1  ? rd_l  : '0;
    assign d_2l = has_2l1 ? rd_2l : '0;

    // Stage 2 products and stage 3 sums. Wrap-around in the sums is harmless:
    // the true values always fit the exact widths.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pa2   <= '0;
            pb2   <= '0;
            ea2   <= '0;
            eb2   <= '0;
            idx2  <= '0;
            p_acc <= '0;
            r_acc <= '0;
            idx3  <= '0;
        end else begin
            pa2  <= (2*DW)'(s1)  * (2*DW)'(d_l);
            pb2  <= (2*DW)'(d_l) * (2*DW)'(d_2l);
            ea2  <= (2*DW)'(s1)  * (2*DW)'(s1);
            eb2  <= (2*DW)'(d_l) * (2*DW)'(d_l);
            idx2 <= idx1;
            if (vld_pipe[1]) begin
                p_acc <= p_acc + P_W'(pa2) - P_W'(pb2);
                r_acc <= r_acc + R_W'($unsigned(ea2)) - R_W'($unsigned(eb2));
                idx3  <= idx2;
            end
        end
    end

    // Stage 4 compare: P/R >= THR/256 without division.
    logic [P_W+7:0] cmp_lhs, cmp_rhs;
    logic           p_pos, hit;

    assign cmp_lhs = {p_acc, 8'd0};
    assign cmp_rhs = (P_W+8)'(r_acc) * (P_W+8)'(THR);
    assign p_pos   = !p_acc[P_W-1] && (p_acc != '0);
    assign hit     = p_pos && (r_acc >= R_W'(MIN_ENERGY)) && (cmp_lhs >= cmp_rhs);

    sc_state_e             state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic signed [P_W-1:0] pmax, pmax_nxt;
    logic [IDX_W-1:0]      pidx, pidx_nxt, peak_nxt;
    logic                  det_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_WARMUP;
            cnt        <= '0;
            pmax       <= '0;
            pidx       <= '0;
            o_detect   <= 1'b0;
            o_peak_idx <= '0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pmax       <= pmax_nxt;
            pidx       <= pidx_nxt;
            o_detect   <= det_nxt;
            o_peak_idx <= peak_nxt;
            o_busy     <= (state_nxt != ST_SEARCH);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pmax_nxt  = pmax;
        pidx_nxt  = pidx;
        peak_nxt  = o_peak_idx;
        det_nxt   = 1'b0;
        if (vld_pipe[2]) begin
            unique case (state)
                ST_WARMUP: begin
                    if (cnt == CNT_W'(BUF_D - 1)) begin
                        state_nxt = ST_SEARCH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_SEARCH: begin
                    if (hit) begin
                        state_nxt = ST_TRACK;
                        pmax_nxt  = p_acc;
                        pidx_nxt  = idx3;
                        cnt_nxt   = '0;
                    end
                end
                ST_TRACK: begin
                    if (!hit) begin
                        det_nxt   = 1'b1;
                        peak_nxt  = pidx;
                        state_nxt = ST_HOLDOFF;
                        cnt_nxt   = '0;
                    end else begin
                        // strict > keeps the earlier index on ties
                        if (p_acc > pmax) begin
                            pmax_nxt = p_acc;
                            pidx_nxt = idx3;
                        end
                        if (cnt == CNT_W'(TRACK_MAX - 1)) begin
                            det_nxt   = 1'b1;
                            peak_nxt  = pidx_nxt;
                            state_nxt = ST_HOLDOFF;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == CNT_W'(HOLDOFF - 1)) begin
                        state_nxt = ST_SEARCH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = ST_WARMUP;
            endcase
        end
    end

`ifdef SC_DET_DEBUG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_metric_p     <= '0;
            o_metric_r     <= '0;
            o_metric_valid <= 1'b0;
        end else begin
            o_metric_valid <= vld_pipe[2];
            if (vld_pipe[2]) begin
                o_metric_p <= p_acc;
                o_metric_r <= r_acc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_schmidl_cox_detector.sv
// Scoreboard bench for schmidl_cox_detector: each preamble that must be
// detected pushes its expected peak index when driven; the monitor pops on
// o_detect. With SC_DET_DEBUG_EN a direct windowed-sum model of P is also
// pushed per sample and checked against o_metric_p.
module tb_schmidl_cox_detector;
    import schmidl_cox_detector_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic [DW-1:0]    i_data = DW'(MID);
    logic             o_detect, o_busy;
    logic [IDX_W-1:0] o_peak_idx;
`ifdef SC_DET_DEBUG_EN
    logic signed [P_W-1:0] o_metric_p;
    logic [R_W-1:0]        o_metric_r;
    logic                  o_metric_valid;
`endif

    int               total = 0, bad = 0, det_cnt = 0;
    logic [IDX_W-1:0] exp_q[$];
    logic [IDX_W-1:0] tb_idx = '0;
    bit               gaps = 1'b0;
    int               win[2*L];
    int               p_q[$];

    always #5 clk = ~clk;

    schmidl_cox_detector dut (
        .clk        (clk),
        .reset      (rst_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_detect   (o_detect),
        .o_peak_idx (o_peak_idx),
        .o_busy     (o_busy)
`ifdef SC_DET_DEBUG_EN
        ,
        .o_metric_p     (o_metric_p),
        .o_metric_r     (o_metric_r),
        .o_metric_valid (o_metric_valid)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_detect) begin
            det_cnt++;
            if (exp_q.size() == 0) chk("spurious_det", 32'(o_detect), 32'd0);
            else chk("peak_idx", 32'(o_peak_idx), 32'(exp_q.pop_front()));
        end
    end

`ifdef SC_DET_DEBUG_EN
    always @(negedge clk) begin
        if (o_metric_valid && p_q.size() != 0)
            chk("metric_p", 32'(o_metric_p), 32'(p_q.pop_front()));
    end
`endif

    task automatic send(input logic [DW-1:0] d);
        int p;
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        tb_idx++;
        for (int k = 2*L-1; k > 0; k--) win[k] = win[k-1];
        win[0] = int'(d) - MID;
        p = 0;
        for (int k = 0; k < L; k++) p += win[k] * win[k+L];
        p_q.push_back(p);
        if (gaps) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic silence(input int n);
        for (int i = 0; i < n; i++) send(DW'(MID));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    // Two identical halves of +/-100 around midscale: every sample has the
    // same energy, so P climbs strictly to the last preamble sample.
    task automatic preamble(input bit expect_det);
        logic [DW-1:0] half[L];
        for (int i = 0; i < L; i++)
            half[i] = ($urandom_range(0, 1) != 0) ? DW'(MID + 100) : DW'(MID - 100);
        for (int h = 0; h < 2; h++)
            for (int i = 0; i < L; i++) begin
                if (h == 1 && i == L-1 && expect_det) exp_q.push_back(tb_idx);
                send(half[i]);
            end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_valid = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        p_q.delete();
        tb_idx = '0;
        for (int k = 0; k < 2*L; k++) win[k] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic finish_case(input string tag, input int d0, input int n_exp);
        idle(8);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_ndet"}, 32'(det_cnt - d0), 32'(n_exp));
    endtask

    initial begin
        int d0;
        for (int k = 0; k < 2*L; k++) win[k] = 0;
        #12;
        chk("rst_detect", 32'(o_detect), 32'd0);
        chk("rst_peak", 32'(o_peak_idx), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);

        // silence
        do_reset();
        d0 = det_cnt;
        silence(10);
        idle(6);
        chk("busy_warmup", 32'(o_busy), 32'd1);
        silence(990);
        finish_case("silence", d0, 0);
        chk("busy_search", 32'(o_busy), 32'd0);

        // clean preamble, continuous then 1010 valid pattern
        for (int g = 0; g < 2; g++) begin
            gaps = (g != 0);
            do_reset();
            d0 = det_cnt;
            silence(200);
            preamble(1'b1);
            silence(400);
            finish_case(gaps ? "gaps" : "clean", d0, 1);
            chk(gaps ? "gaps_idx_hold" : "clean_idx_hold", 32'(o_peak_idx), 32'd327);
        end
        gaps = 1'b0;

        // second preamble 150 samples after the first: inside hold-off
        do_reset();
        d0 = det_cnt;
        silence(200);
        preamble(1'b1);
        silence(22);
        preamble(1'b0);
        silence(500);
        finish_case("hold150", d0, 1);

        // 400 samples apart: both detect
        do_reset();
        d0 = det_cnt;
        silence(200);
        preamble(1'b1);
        silence(272);
        preamble(1'b1);
        silence(400);
        finish_case("hold400", d0, 2);

        // reset while tracking
        do_reset();
        d0 = det_cnt;
        silence(200);
        preamble(1'b0);
        silence(5);
        idle(6);
        chk("busy_track", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_detect", 32'(o_detect), 32'd0);
        chk("midrst_peak", 32'(o_peak_idx), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        do_reset();
        silence(127);
        idle(6);
        chk("rewarm_busy127", 32'(o_busy), 32'd1);
        silence(1);
        idle(6);
        chk("rewarm_busy128", 32'(o_busy), 32'd0);
        silence(300);
        finish_case("midrst", d0, 0);

        // peak index across the 16-bit counter wrap: 0xFFFF+5 -> 4
        do_reset();
        d0 = det_cnt;
        silence(65413);
        preamble(1'b1);
        silence(400);
        finish_case("wrap", d0, 1);
        chk("wrap_idx_hold", 32'(o_peak_idx), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
